// File: rtl/row_reduce_engine.sv
// Two-row Gauss-Jordan reduction engine: reduces a loaded 2 x NCOLS augmented
// matrix to [1 0 x ; 0 1 y] one column per cycle, then checks the player's answer.
module row_reduce_engine #(
  parameter int WIDTH = 8,
  parameter int NCOLS = 3,
  localparam int CW = $clog2(NCOLS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_en,
  input  logic             load_row,
  input  logic [CW-1:0]    load_col,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             ans_valid,
  input  logic [WIDTH-1:0] ans_x,
  input  logic [WIDTH-1:0] ans_y,
  input  logic             rd_row,
  input  logic [CW-1:0]    rd_col,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             div_err,
  output logic             correct,
  output logic             wrong
);

  localparam logic [CW:0]   NC_EXT = (CW+1)'(NCOLS);
  localparam logic [CW-1:0] LAST_C = CW'(NCOLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_N1, S_P2, S_E2, S_P3, S_N3, S_P4, S_E4, S_WAIT_ANS, S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_m [2][NCOLS];
  logic [WIDTH-1:0] r_pv;
  logic [CW-1:0]    r_col;
  logic             r_done;
  logic             r_correct;
  logic             r_wrong;

  logic             w_cmdOk;
  logic             w_colStep;
  logic             w_lastCol;
  logic             w_answerMatch;
  logic [WIDTH-1:0] w_m0c;
  logic [WIDTH-1:0] w_m1c;
  logic [WIDTH-1:0] w_prod0;
  logic [WIDTH-1:0] w_prod1;

  assign w_cmdOk   = (r_state == S_IDLE) || (r_state == S_WAIT_ANS) || (r_state == S_ERR);
  assign w_colStep = (r_state == S_N1) || (r_state == S_E2) ||
                     (r_state == S_N3) || (r_state == S_E4);
  assign w_lastCol = (r_col == LAST_C);

  assign w_m0c   = r_m[0][r_col];
  assign w_m1c   = r_m[1][r_col];
  assign w_prod0 = w_m0c * r_pv;
  assign w_prod1 = w_m1c * r_pv;

  assign w_answerMatch = (ans_x == r_m[0][NCOLS-1]) && (ans_y == r_m[1][NCOLS-1]);

  assign rd_data = ({1'b0, rd_col} < NC_EXT) ? r_m[rd_row][rd_col] : '0;
  assign busy    = !w_cmdOk;
  assign div_err = (r_state == S_ERR);
  assign done    = r_done;
  assign correct = r_correct;
  assign wrong   = r_wrong;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Pivot states check the live matrix element, so a zero pivot never reaches a divide.
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      S_IDLE, S_WAIT_ANS, S_ERR: if (start) w_stateNext = S_P1;
      S_P1:    w_stateNext = (r_m[0][0] == '0) ? S_ERR : S_N1;
      S_N1:    if (w_lastCol) w_stateNext = S_P2;
      S_P2:    w_stateNext = S_E2;
      S_E2:    if (w_lastCol) w_stateNext = S_P3;
      S_P3:    w_stateNext = (r_m[1][1] == '0) ? S_ERR : S_N3;
      S_N3:    if (w_lastCol) w_stateNext = S_P4;
      S_P4:    w_stateNext = S_E4;
      S_E4:    if (w_lastCol) w_stateNext = S_WAIT_ANS;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_col <= '0;
    end else if (w_colStep) begin
      r_col <= w_lastCol ? '0 : r_col + 1'b1;
    end else begin
      r_col <= '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < NCOLS; c++) begin
          r_m[r][c] <= '0;
        end
      end
      r_pv <= '0;
    end else begin
      if (w_cmdOk && load_en && ({1'b0, load_col} < NC_EXT)) begin
        r_m[load_row][load_col] <= load_data;
      end
      unique case (r_state)
        S_P1:    r_pv <= r_m[0][0];
        S_P2:    r_pv <= r_m[1][0];
        S_P3:    r_pv <= r_m[1][1];
        S_P4:    r_pv <= r_m[0][1];
        S_N1:    r_m[0][r_col] <= w_m0c / r_pv;
        S_E2:    r_m[1][r_col] <= w_m1c - w_prod0;
        S_N3:    r_m[1][r_col] <= w_m1c / r_pv;
        S_E4:    r_m[0][r_col] <= w_m0c - w_prod1;
        default: ;
      endcase
    end
  end

  // A restart clears the previous verdict; it takes priority over a same-cycle answer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_done    <= 1'b0;
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
    end else begin
      r_done <= (r_state == S_E4) && w_lastCol;
      if (w_cmdOk && start) begin
        r_correct <= 1'b0;
        r_wrong   <= 1'b0;
      end else if ((r_state == S_WAIT_ANS) && ans_valid) begin
        r_correct <= w_answerMatch;
        r_wrong   <= !w_answerMatch;
      end
    end
  end

endmodule
